// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and pipe_hazard_ctrl.
// master: the datapath side. It drives the ID/EX/MEM hazard inputs and receives
//         the stall, flush and MDU status outputs.
// slave:  the controller side.
// CNT_W sets the width of stall_cnt. It must match the controller's CNT_W.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_mdu_start;
    logic             id_mdu_div;
    logic [4:0]       ex_rw;
    logic             ex_regwr;
    logic             ex_memtoreg;
    logic [4:0]       mem_rw;
    logic             mem_regwr;
    logic             ex_taken;
    logic             pc_stall;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             mdu_busy;
    logic             mdu_done;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_mdu_start, id_mdu_div,
        output ex_rw, ex_regwr, ex_memtoreg, mem_rw, mem_regwr, ex_taken,
        input  pc_stall, ifid_stall, ifid_flush, idex_bubble, mdu_busy, mdu_done, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_mdu_start, id_mdu_div,
        input  ex_rw, ex_regwr, ex_memtoreg, mem_rw, mem_regwr, ex_taken,
        output pc_stall, ifid_stall, ifid_flush, idex_bubble, mdu_busy, mdu_done, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage pipeline around exec.
// - Detects RAW hazards between ID and EX/MEM and stalls PC and IF/ID while
//   bubbling ID/EX.
// - Flushes IF/ID and bubbles ID/EX on a branch or jump taken in EX.
// - Holds a multiply/divide op in ID for the MDU latency. mdu_done pulses on
//   the cycle the op advances.
// - stall_cnt counts pc_stall cycles and saturates at its maximum value.
// Ports: clk, rst_n (asynchronous, active low); bus (pipe_hazard_ctrl_if.slave).
// Config macro PIPE_FWD_EN: define it when exec forwards results. Only
// load-use hazards then stall. When it is undefined, any producer in EX or MEM
// stalls the consumer in ID.
module pipe_hazard_ctrl #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 16
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_ctrl_if.slave bus
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam int unsigned MaxCyc = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int unsigned MdW    = $clog2(MaxCyc);

    logic [1:0]       state_q, state_d;
    logic [MdW-1:0]   mdu_cnt_q, mdu_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic ex_rs_hit, ex_rt_hit, ex_hit;
    logic load_use, raw_haz;
    logic stall_c, flush_c, bubble_c, busy_c, done_c;

    // Register 0 is hardwired, so a producer writing r0 never creates a hazard.
    assign ex_rs_hit = bus.id_use_rs && (bus.id_rs == bus.ex_rw);
    assign ex_rt_hit = bus.id_use_rt && (bus.id_rt == bus.ex_rw);
    assign ex_hit    = (bus.ex_rw != 5'd0) && (ex_rs_hit || ex_rt_hit);
    assign load_use  = bus.ex_regwr && bus.ex_memtoreg && ex_hit;

`ifdef PIPE_FWD_EN
    logic unused_mem;
    assign unused_mem = ^{bus.mem_rw, bus.mem_regwr};
    assign raw_haz    = load_use;
`else
    logic mem_hit;
    assign mem_hit = bus.mem_regwr && (bus.mem_rw != 5'd0) &&
                     ((bus.id_use_rs && (bus.id_rs == bus.mem_rw)) ||
                      (bus.id_use_rt && (bus.id_rt == bus.mem_rw)));
    assign raw_haz = load_use || (bus.ex_regwr && ex_hit) || mem_hit;
`endif

    always_comb begin
        state_d   = state_q;
        mdu_cnt_d = mdu_cnt_q;
        stall_c   = 1'b0;
        flush_c   = 1'b0;
        bubble_c  = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        // A taken branch outranks everything. In RUN/DONE it is a protocol
        // error, so the MDU op is abandoned and the flush is handled as in IDLE.
        if (bus.ex_taken) begin
            flush_c   = 1'b1;
            bubble_c  = 1'b1;
            state_d   = StIdle;
            mdu_cnt_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (raw_haz) begin
                        stall_c  = 1'b1;
                        bubble_c = 1'b1;
                    end else if (bus.id_mdu_start) begin
                        stall_c   = 1'b1;
                        bubble_c  = 1'b1;
                        state_d   = StRun;
                        mdu_cnt_d = bus.id_mdu_div ? MdW'(DIV_CYCLES - 1) : MdW'(MUL_CYCLES - 1);
                    end
                end
                StRun: begin
                    busy_c    = 1'b1;
                    stall_c   = 1'b1;
                    bubble_c  = 1'b1;
                    mdu_cnt_d = mdu_cnt_q - MdW'(1);
                    // Leave when this decrement reaches zero. That gives N-1 RUN cycles.
                    if (mdu_cnt_q <= MdW'(1)) begin
                        state_d   = StDone;
                        mdu_cnt_d = '0;
                    end
                end
                StDone: begin
                    done_c  = 1'b1;
                    state_d = StIdle;
                end
                default: begin
                    state_d   = StIdle;
                    mdu_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mdu_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mdu_cnt_q   <= mdu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // The outputs are combinational from the inputs, so they are gated by the
    // reset. Otherwise ex_taken could assert a flush while the design is held in reset.
    assign bus.pc_stall    = rst_n & stall_c;
    assign bus.ifid_stall  = rst_n & stall_c;
    assign bus.ifid_flush  = rst_n & flush_c;
    assign bus.idex_bubble = rst_n & bubble_c;
    assign bus.mdu_busy    = rst_n & busy_c;
    assign bus.mdu_done    = rst_n & done_c;
    assign bus.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(16)) bus ();
    pipe_hazard_ctrl_if #(.CNT_W(4))  bus2 ();

    pipe_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Narrow-counter copy that sees the same stimulus and is used for the saturation check.
    pipe_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(4)) dut_sat (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (bus2)
    );

    assign bus2.id_rs        = bus.id_rs;
    assign bus2.id_rt        = bus.id_rt;
    assign bus2.id_use_rs    = bus.id_use_rs;
    assign bus2.id_use_rt    = bus.id_use_rt;
    assign bus2.id_mdu_start = bus.id_mdu_start;
    assign bus2.id_mdu_div   = bus.id_mdu_div;
    assign bus2.ex_rw        = bus.ex_rw;
    assign bus2.ex_regwr     = bus.ex_regwr;
    assign bus2.ex_memtoreg  = bus.ex_memtoreg;
    assign bus2.mem_rw       = bus.mem_rw;
    assign bus2.mem_regwr    = bus.mem_regwr;
    assign bus2.ex_taken     = bus.ex_taken;

    typedef struct packed {
        logic        pc;
        logic        ifs;
        logic        fl;
        logic        bub;
        logic        busy;
        logic        done;
        logic [15:0] cnt;
        logic [3:0]  cnt2;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_cnt  = 16'd0;
    logic [3:0]  exp_cnt2 = 4'd0;

    task automatic chk(input string tag, input string name, input logic [15:0] obs,
                       input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, name, obs, exp);
        end
    endtask

    // Push the expected outputs for this cycle, then compare them at the falling edge.
    task automatic step(input string tag, input logic pc, input logic fl, input logic bub,
                        input logic busy, input logic done);
        exp_t e;
        e = '{pc: pc, ifs: pc, fl: fl, bub: bub, busy: busy, done: done,
              cnt: exp_cnt, cnt2: exp_cnt2};
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk(tag, "pc_stall",    {15'd0, bus.pc_stall},    {15'd0, e.pc});
        chk(tag, "ifid_stall",  {15'd0, bus.ifid_stall},  {15'd0, e.ifs});
        chk(tag, "ifid_flush",  {15'd0, bus.ifid_flush},  {15'd0, e.fl});
        chk(tag, "idex_bubble", {15'd0, bus.idex_bubble}, {15'd0, e.bub});
        chk(tag, "mdu_busy",    {15'd0, bus.mdu_busy},    {15'd0, e.busy});
        chk(tag, "mdu_done",    {15'd0, bus.mdu_done},    {15'd0, e.done});
        chk(tag, "stall_cnt",   bus.stall_cnt,            e.cnt);
        chk(tag, "stall_cnt4",  {12'd0, bus2.stall_cnt},  {12'd0, e.cnt2});
        if (rst_n && pc) exp_cnt = exp_cnt + 16'd1;
        if (rst2_n && pc && exp_cnt2 != 4'd15) exp_cnt2 = exp_cnt2 + 4'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_rs        = 5'd0;
        bus.id_rt        = 5'd0;
        bus.id_use_rs    = 1'b0;
        bus.id_use_rt    = 1'b0;
        bus.id_mdu_start = 1'b0;
        bus.id_mdu_div   = 1'b0;
        bus.ex_rw        = 5'd0;
        bus.ex_regwr     = 1'b0;
        bus.ex_memtoreg  = 1'b0;
        bus.mem_rw       = 5'd0;
        bus.mem_regwr    = 1'b0;
        bus.ex_taken     = 1'b0;
    endtask

    task automatic set_load_use();
        bus.ex_memtoreg = 1'b1;
        bus.ex_regwr    = 1'b1;
        bus.ex_rw       = 5'd5;
        bus.id_rs       = 5'd5;
        bus.id_use_rs   = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        clear_inputs();
        bus.ex_taken = 1'b1;
        @(posedge clk);
        #1;
        // Reset held with ex_taken high: every output stays quiet.
        step("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step("rel_flush", 0, 1, 1, 0, 0);

        // Load-use hazard, then the same case with r0 as the destination.
        clear_inputs();
        set_load_use();
        step("load_use", 1, 0, 1, 0, 0);
        bus.ex_rw = 5'd0;
        bus.id_rs = 5'd0;
        step("lu_r0", 0, 0, 0, 0, 0);

        // ALU RAW hazard on rt, first with the producer in EX and then in MEM.
        clear_inputs();
        bus.ex_regwr  = 1'b1;
        bus.ex_rw     = 5'd7;
        bus.id_rt     = 5'd7;
        bus.id_use_rt = 1'b1;
`ifdef PIPE_FWD_EN
        step("alu_ex", 0, 0, 0, 0, 0);
`else
        step("alu_ex", 1, 0, 1, 0, 0);
`endif
        bus.ex_regwr  = 1'b0;
        bus.ex_rw     = 5'd0;
        bus.mem_regwr = 1'b1;
        bus.mem_rw    = 5'd7;
`ifdef PIPE_FWD_EN
        step("alu_mem", 0, 0, 0, 0, 0);
`else
        step("alu_mem", 1, 0, 1, 0, 0);
`endif
        bus.mem_regwr = 1'b0;
        step("alu_clear", 0, 0, 0, 0, 0);

        // A flush outranks both a load-use hazard and an MDU start.
        clear_inputs();
        set_load_use();
        bus.id_mdu_start = 1'b1;
        bus.ex_taken     = 1'b1;
        step("flush_prio", 0, 1, 1, 0, 0);
        clear_inputs();
        step("flush_idle", 0, 0, 0, 0, 0);

        // Multiply: 4 stall cycles (1 start cycle and 3 busy cycles), then done.
        bus.id_mdu_start = 1'b1;
        step("mul_start", 1, 0, 1, 0, 0);
        bus.id_mdu_div = 1'b1;
        for (int i = 0; i < 3; i++) step("mul_run", 1, 0, 1, 1, 0);
        step("mul_done", 0, 0, 0, 0, 1);
        clear_inputs();
        step("mul_after", 0, 0, 0, 0, 0);

        // Divide: 32 stall cycles, then done on cycle 33.
        bus.id_mdu_start = 1'b1;
        bus.id_mdu_div   = 1'b1;
        step("div_start", 1, 0, 1, 0, 0);
        for (int i = 0; i < 31; i++) step("div_run", 1, 0, 1, 1, 0);
        step("div_done", 0, 0, 0, 0, 1);
        clear_inputs();
        step("div_after", 0, 0, 0, 0, 0);

        // Reset asserted during the third RUN cycle of a divide.
        bus.id_mdu_start = 1'b1;
        bus.id_mdu_div   = 1'b1;
        step("div2_start", 1, 0, 1, 0, 0);
        step("div2_run", 1, 0, 1, 1, 0);
        step("div2_run", 1, 0, 1, 1, 0);
        rst_n   = 1'b0;
        exp_cnt = 16'd0;
        step("rst_mid", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        clear_inputs();
        step("rst_after", 0, 0, 0, 0, 0);
        step("rst_idle", 0, 0, 0, 0, 0);

        // 4-bit counter: 14 load-use stalls, then a multiply saturates it at 15.
        rst2_n = 1'b1;
        set_load_use();
        for (int i = 0; i < 14; i++) step("sat_lu", 1, 0, 1, 0, 0);
        clear_inputs();
        step("sat_14", 0, 0, 0, 0, 0);
        bus.id_mdu_start = 1'b1;
        step("sat_mul_start", 1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step("sat_mul_run", 1, 0, 1, 1, 0);
        step("sat_mul_done", 0, 0, 0, 0, 1);
        clear_inputs();
        step("sat_final", 0, 0, 0, 0, 0);
        chk("sat_final", "cnt4_max", {12'd0, bus2.stall_cnt}, 16'd15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
